ps2_kbd_ctrl: RTL and testbench
===============================

// Module: ps2_kbd_ctrl
// PURPOSE
//  Sequences the byte stream from the PS/2 receive front end into ASCII keystrokes for the LC3
//  keyboard device registers (KBSR/KBDR). Decodes set-2 prefixes (E0 extended, F0 break) and
//  tracks Shift/CapsLock. Buffers translated characters in a small FIFO that the LC3 bus drains.
//  Sits between the PS/2 receiver and the memory-mapped I/O decoder.
// PARAMETERS
//  FIFO_DEPTH      4       character buffer entries, power of 2, >=2
//  PREFIX_TIMEOUT  50000   clk cycles allowed after an E0/F0 prefix before FSM aborts to IDLE
// PORTS
//  clk         in   1   system clock
//  rst_n       in   1   reset, synchronous, active-low
//  frame_vld   in   1   1-cycle pulse: new PS/2 byte on frame_data/frame_err
//  frame_data  in   8   received scan-code byte
//  frame_err   in   1   parity/framing error for this byte (qualified by frame_vld)
//  kbd_rd      in   1   1-cycle pulse: LC3 read of KBDR, pops FIFO head
//  kbd_rdy     out  1   FIFO not empty (KBSR[15])
//  kbd_data    out  8   FIFO head ASCII, 8'h00 when empty (KBDR[7:0])
//  kbd_ovf     out  1   sticky: character dropped because FIFO full
//  err_cnt     out  8   saturating count of frames with frame_err
// BEHAVIOUR
//  Reset: FSM=IDLE, FIFO empty, kbd_rdy=0, kbd_data=0, kbd_ovf=0, err_cnt=0, shift=0, caps=0.
//  frame_err=1 byte: discarded, err_cnt+1 (holds at 255), FSM returns to IDLE.
//  FSM (acts only on frame_vld with frame_err=0, except timeout):
//   IDLE   : E0->EXT; F0->BRK; else make code -> EMIT.
//   EXT    : F0->EXT_BRK; any other byte -> IDLE (extended makes ignored).
//   EXT_BRK: any byte -> IDLE (extended breaks ignored).
//   BRK    : 12/59 -> clear shift; other -> no action; -> IDLE.
//   EMIT   : 1 cycle; translate latched make code; printable -> push FIFO; -> IDLE.
//  Timeout: counter cleared on entry to EXT/BRK/EXT_BRK, counts each cycle in them; reaching
//   PREFIX_TIMEOUT -> IDLE. frame_vld during EMIT is ignored.
//  Modifiers (in EMIT, not pushed): 12 or 59 make -> shift=1; 58 make -> caps toggles.
//   Typematic repeat of 58 toggles again.
//  Translation (US set-2): letters 1C=a,32=b,21=c,23=d,24=e,2B=f,34=g,33=h,43=i,3B=j,42=k,
//   4B=l,3A=m,31=n,44=o,4D=p,15=q,2D=r,1B=s,2C=t,3C=u,2A=v,1D=w,22=x,35=y,1A=z; uppercase
//   iff shift XOR caps. Digits 45,16,1E,26,25,2E,36,3D,3E,46 = '0'..'9'; with shift
//   ')!@#$%^&*('. 29=20h, 5A=0Ah, 66=08h, 76=1Bh. All other codes dropped, no side effects.
//  Latency: frame_vld (cycle N) of printable make in IDLE -> FIFO write at end of N+1 ->
//   kbd_rdy=1, kbd_data valid in cycle N+2.
//  FIFO: kbd_rd pops at clock edge; kbd_rd on empty ignored. Push while full: dropped,
//   kbd_ovf=1 until reset. Push+pop in one cycle: both happen; never overflow when full,
//   count unchanged; when empty, pop ignored, push lands. Pointers wrap modulo FIFO_DEPTH.
//  kbd_rdy/kbd_data are registered from FIFO state, no combinational path from kbd_rd.
//  rst_n low mid-sequence (any state, FIFO occupied) -> full reset values on the next edge.
// TESTING
//  1) 1C -> kbd_rdy=1 two cycles after frame_vld, kbd_data=61h; kbd_rd -> kbd_rdy=0, data=00h.
//  2) 12,1C,F0,12,1C -> FIFO holds 41h then 61h.
//  3) 58,F0,58,16 -> 31h with caps=1 (caps affects letters only); 58,12,1C -> 61h.
//  4) E0,75 and E0,F0,75 -> no push; E0 then 60000 idle cycles, 1C -> 61h pushed.
//  5) 5 make codes, no reads, DEPTH=4 -> 4 entries, kbd_ovf=1; pop + push same cycle keeps 4.
//  6) frame_err=1 x300 -> err_cnt=255; F0 then error byte then 1C -> 61h pushed.

Source files
------------

// File: rtl/ps2_kbd_ctrl.sv
// PS/2 set-2 keyboard sequencer: scan-code bytes in, ASCII characters out through a small FIFO
// that backs the LC3 KBSR/KBDR device registers.
module ps2_kbd_ctrl #(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned PREFIX_TIMEOUT = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_vld,
  input  logic [7:0] frame_data,
  input  logic       frame_err,
  input  logic       kbd_rd,
  output logic       kbd_rdy,
  output logic [7:0] kbd_data,
  output logic       kbd_ovf,
  output logic [7:0] err_cnt
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned TMO_W = $clog2(PREFIX_TIMEOUT + 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXT     = 3'd1,
    ST_BRK     = 3'd2,
    ST_EXT_BRK = 3'd3,
    ST_EMIT    = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [7:0]         make_q, make_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               shift_q, shift_d;
  logic               caps_q, caps_d;
  logic [7:0]         err_q, err_d;
  logic               push;
  logic [7:0]         push_char;

  logic [7:0]         mem_q [FIFO_DEPTH];
  logic [7:0]         mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               rdy_q, rdy_d;
  logic [7:0]         data_q, data_d;

  logic               frame_ok;
  logic               tmo_hit;
  logic [8:0]         xl;

  // US set-2 make code to ASCII; bit 8 flags a printable/pushable result
  function automatic logic [8:0] xlate(input logic [7:0] code, input logic shift,
                                       input logic caps);
    logic [7:0] lc;
    logic       letter;
    logic       vld;
    logic [7:0] ch;
    lc     = 8'h00;
    letter = 1'b0;
    vld    = 1'b1;
    ch     = 8'h00;
    case (code)
      8'h1C: begin lc = 8'h61; letter = 1'b1; end
      8'h32: begin lc = 8'h62; letter = 1'b1; end
      8'h21: begin lc = 8'h63; letter = 1'b1; end
      8'h23: begin lc = 8'h64; letter = 1'b1; end
      8'h24: begin lc = 8'h65; letter = 1'b1; end
      8'h2B: begin lc = 8'h66; letter = 1'b1; end
      8'h34: begin lc = 8'h67; letter = 1'b1; end
      8'h33: begin lc = 8'h68; letter = 1'b1; end
      8'h43: begin lc = 8'h69; letter = 1'b1; end
      8'h3B: begin lc = 8'h6A; letter = 1'b1; end
      8'h42: begin lc = 8'h6B; letter = 1'b1; end
      8'h4B: begin lc = 8'h6C; letter = 1'b1; end
      8'h3A: begin lc = 8'h6D; letter = 1'b1; end
      8'h31: begin lc = 8'h6E; letter = 1'b1; end
      8'h44: begin lc = 8'h6F; letter = 1'b1; end
      8'h4D: begin lc = 8'h70; letter = 1'b1; end
      8'h15: begin lc = 8'h71; letter = 1'b1; end
      8'h2D: begin lc = 8'h72; letter = 1'b1; end
      8'h1B: begin lc = 8'h73; letter = 1'b1; end
      8'h2C: begin lc = 8'h74; letter = 1'b1; end
      8'h3C: begin lc = 8'h75; letter = 1'b1; end
      8'h2A: begin lc = 8'h76; letter = 1'b1; end
      8'h1D: begin lc = 8'h77; letter = 1'b1; end
      8'h22: begin lc = 8'h78; letter = 1'b1; end
      8'h35: begin lc = 8'h79; letter = 1'b1; end
      8'h1A: begin lc = 8'h7A; letter = 1'b1; end
      8'h45: ch = shift ? 8'h29 : 8'h30;
      8'h16: ch = shift ? 8'h21 : 8'h31;
      8'h1E: ch = shift ? 8'h40 : 8'h32;
      8'h26: ch = shift ? 8'h23 : 8'h33;
      8'h25: ch = shift ? 8'h24 : 8'h34;
      8'h2E: ch = shift ? 8'h25 : 8'h35;
      8'h36: ch = shift ? 8'h5E : 8'h36;
      8'h3D: ch = shift ? 8'h26 : 8'h37;
      8'h3E: ch = shift ? 8'h2A : 8'h38;
      8'h46: ch = shift ? 8'h28 : 8'h39;
      8'h29: ch = 8'h20;
      8'h5A: ch = 8'h0A;
      8'h66: ch = 8'h08;
      8'h76: ch = 8'h1B;
      default: vld = 1'b0;
    endcase
    if (letter) ch = (shift ^ caps) ? (lc - 8'h20) : lc;
    return {vld, ch};
  endfunction

  assign frame_ok = frame_vld & ~frame_err;
  assign tmo_hit  = (tmo_q == TMO_W'(PREFIX_TIMEOUT - 1));
  assign xl       = xlate(make_q, shift_q, caps_q);

  // Prefix decoding, modifier tracking, error counting and character emission
  always_comb begin
    state_d   = state_q;
    make_d    = make_q;
    tmo_d     = tmo_q;
    shift_d   = shift_q;
    caps_d    = caps_q;
    err_d     = err_q;
    push      = 1'b0;
    push_char = 8'h00;
    case (state_q)
      ST_IDLE: begin
        if (frame_ok) begin
          tmo_d = '0;
          if (frame_data == 8'hE0)      state_d = ST_EXT;
          else if (frame_data == 8'hF0) state_d = ST_BRK;
          else begin
            make_d  = frame_data;
            state_d = ST_EMIT;
          end
        end
      end
      ST_EXT: begin
        if (frame_ok) begin
          tmo_d   = '0;
          state_d = (frame_data == 8'hF0) ? ST_EXT_BRK : ST_IDLE;
        end else if (tmo_hit) begin
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_EXT_BRK: begin
        if (frame_ok || tmo_hit) state_d = ST_IDLE;
        else                     tmo_d   = tmo_q + TMO_W'(1);
      end
      ST_BRK: begin
        if (frame_ok) begin
          if (frame_data == 8'h12 || frame_data == 8'h59) shift_d = 1'b0;
          state_d = ST_IDLE;
        end else if (tmo_hit) begin
          state_d = ST_IDLE;
        end else begin
          tmo_d = tmo_q + TMO_W'(1);
        end
      end
      ST_EMIT: begin
        if (make_q == 8'h12 || make_q == 8'h59) shift_d = 1'b1;
        if (make_q == 8'h58)                    caps_d  = ~caps_q;
        push      = xl[8];
        push_char = xl[7:0];
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A bad frame aborts any prefix in progress; EMIT finishes on its own
    if (frame_vld && frame_err) begin
      if (err_q != 8'hFF) err_d = err_q + 8'd1;
      if (state_q != ST_EMIT) state_d = ST_IDLE;
    end
  end

  // FIFO pointer/count update and registered head presentation
  always_comb begin
    logic pop;
    logic full;
    mem_d  = mem_q;
    wr_d   = wr_q;
    rd_d   = rd_q;
    cnt_d  = cnt_q;
    ovf_d  = ovf_q;
    pop    = kbd_rd && (cnt_q != '0);
    full   = (cnt_q == CNT_W'(FIFO_DEPTH));
    if (pop) begin
      rd_d  = rd_q + PTR_W'(1);
      cnt_d = cnt_d - CNT_W'(1);
    end
    if (push) begin
      if (!full || pop) begin
        mem_d[wr_q] = push_char;
        wr_d        = wr_q + PTR_W'(1);
        cnt_d       = cnt_d + CNT_W'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end
    rdy_d  = (cnt_d != '0);
    data_d = (cnt_d != '0) ? mem_d[rd_d] : 8'h00;
  end

  // State registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      make_q  <= 8'h00;
      tmo_q   <= '0;
      shift_q <= 1'b0;
      caps_q  <= 1'b0;
      err_q   <= 8'h00;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      rdy_q   <= 1'b0;
      data_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      make_q  <= make_d;
      tmo_q   <= tmo_d;
      shift_q <= shift_d;
      caps_q  <= caps_d;
      err_q   <= err_d;
      mem_q   <= mem_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      rdy_q   <= rdy_d;
      data_q  <= data_d;
    end
  end

  assign kbd_rdy  = rdy_q;
  assign kbd_data = data_q;
  assign kbd_ovf  = ovf_q;
  assign err_cnt  = err_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Directed bench for ps2_kbd_ctrl: hand-computed ASCII results for scan-code sequences.
module tb_ps2_kbd_ctrl;

  logic       clk;
  logic       rst_n;
  logic       frame_vld;
  logic [7:0] frame_data;
  logic       frame_err;
  logic       kbd_rd;
  logic       kbd_rdy;
  logic [7:0] kbd_data;
  logic       kbd_ovf;
  logic [7:0] err_cnt;

  int checks;
  int failures;

  ps2_kbd_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_vld  (frame_vld),
    .frame_data (frame_data),
    .frame_err  (frame_err),
    .kbd_rd     (kbd_rd),
    .kbd_rdy    (kbd_rdy),
    .kbd_data   (kbd_data),
    .kbd_ovf    (kbd_ovf),
    .err_cnt    (err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value against its expected value
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One byte pulse followed by an idle cycle so the EMIT cycle never swallows the next byte
  task automatic send(input logic [7:0] b, input logic e = 1'b0);
    frame_vld  = 1'b1;
    frame_data = b;
    frame_err  = e;
    tick();
    frame_vld  = 1'b0;
    frame_err  = 1'b0;
    tick();
  endtask

  task automatic pop();
    kbd_rd = 1'b1;
    tick();
    kbd_rd = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  // Check head then pop it
  task automatic expect_head(input string tag, input logic [7:0] ch);
    chk({tag, "_rdy"}, 32'(kbd_rdy), 32'd1);
    chk({tag, "_data"}, 32'(kbd_data), 32'(ch));
    pop();
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst_n      = 1'b0;
    frame_vld  = 1'b0;
    frame_data = 8'h00;
    frame_err  = 1'b0;
    kbd_rd     = 1'b0;
    tick();
    tick();
    chk("rst_rdy", 32'(kbd_rdy), 32'd0);
    chk("rst_data", 32'(kbd_data), 32'd0);
    chk("rst_ovf", 32'(kbd_ovf), 32'd0);
    chk("rst_err", 32'(err_cnt), 32'd0);
    rst_n = 1'b1;
    tick();

    // 1) latency: pulse in cycle N, visible in N+2
    frame_vld  = 1'b1;
    frame_data = 8'h1C;
    tick();
    frame_vld  = 1'b0;
    chk("t1_rdy_n1", 32'(kbd_rdy), 32'd0);
    tick();
    chk("t1_rdy_n2", 32'(kbd_rdy), 32'd1);
    chk("t1_data", 32'(kbd_data), 32'h61);
    pop();
    chk("t1_rdy_pop", 32'(kbd_rdy), 32'd0);
    chk("t1_data_pop", 32'(kbd_data), 32'h00);
    pop();
    chk("t1_empty_rd", 32'(kbd_rdy), 32'd0);

    // 2) shift make/break
    send(8'h12); send(8'h1C); send(8'hF0); send(8'h12); send(8'h1C);
    expect_head("t2_A", 8'h41);
    expect_head("t2_a", 8'h61);
    chk("t2_empty", 32'(kbd_rdy), 32'd0);

    // 3) caps affects letters only; shift XOR caps
    do_reset();
    send(8'h58); send(8'hF0); send(8'h58); send(8'h16);
    expect_head("t3_digit", 8'h31);
    send(8'h1C);
    expect_head("t3_capsA", 8'h41);
    send(8'h4E);
    chk("t3_unmapped", 32'(kbd_rdy), 32'd0);
    do_reset();
    send(8'h58); send(8'h12); send(8'h1C);
    expect_head("t3_xor", 8'h61);
    send(8'h16);
    expect_head("t3_bang", 8'h21);

    // 4) extended makes/breaks ignored; prefix timeout
    do_reset();
    send(8'hE0); send(8'h1C);
    send(8'hE0); send(8'hF0); send(8'h1C);
    tick();
    chk("t4_ext_nopush", 32'(kbd_rdy), 32'd0);
    send(8'hE0);
    repeat (60000) tick();
    send(8'h1C);
    expect_head("t4_timeout", 8'h61);

    // 5) overflow and simultaneous push/pop when full
    do_reset();
    send(8'h1C); send(8'h32); send(8'h21); send(8'h23);
    chk("t5_ovf_before", 32'(kbd_ovf), 32'd0);
    send(8'h24);
    chk("t5_ovf", 32'(kbd_ovf), 32'd1);
    chk("t5_head", 32'(kbd_data), 32'h61);
    frame_vld  = 1'b1;
    frame_data = 8'h2B;
    tick();
    frame_vld  = 1'b0;
    kbd_rd     = 1'b1;
    tick();
    kbd_rd     = 1'b0;
    tick();
    expect_head("t5_b", 8'h62);
    expect_head("t5_c", 8'h63);
    expect_head("t5_d", 8'h64);
    expect_head("t5_f", 8'h66);
    chk("t5_empty", 32'(kbd_rdy), 32'd0);
    chk("t5_ovf_sticky", 32'(kbd_ovf), 32'd1);

    // 6) error counting saturates; error aborts a pending break
    do_reset();
    for (int i = 0; i < 5; i++) send(8'h1C, 1'b1);
    chk("t6_err5", 32'(err_cnt), 32'd5);
    chk("t6_no_push", 32'(kbd_rdy), 32'd0);
    frame_vld = 1'b1;
    frame_err = 1'b1;
    repeat (295) tick();
    frame_vld = 1'b0;
    frame_err = 1'b0;
    tick();
    chk("t6_err_sat", 32'(err_cnt), 32'd255);
    send(8'hF0); send(8'h00, 1'b1); send(8'h1C);
    expect_head("t6_after_err", 8'h61);
    chk("t6_err_hold", 32'(err_cnt), 32'd255);

    // 7) reset mid-sequence with FIFO occupied and a break pending
    send(8'h12); send(8'h1C); send(8'hF0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("t7_rdy", 32'(kbd_rdy), 32'd0);
    chk("t7_data", 32'(kbd_data), 32'd0);
    chk("t7_err", 32'(err_cnt), 32'd0);
    chk("t7_ovf", 32'(kbd_ovf), 32'd0);
    send(8'h1C);
    expect_head("t7_post", 8'h61);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
